// File: rtl/mips_ifetch.sv
// Instruction-fetch stage: PC, word-addressed instruction memory and a prefetch FIFO
// feeding the execute stage over a valid/ready handshake.
module mips_ifetch #(
  parameter int          ADDR_W     = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       instr,
  output logic [31:0]       pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]       r_mem       [2**ADDR_W];
  logic [31:0]       r_fifo_instr[FIFO_DEPTH];
  logic [31:0]       r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_rd_data;
  logic [31:0]       r_rd_pc;
  logic              r_inflight;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic [CW:0]       w_occ;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_idx;

  // In-flight reads reserve a slot, so a push can never find the FIFO full.
  assign w_occ   = {1'b0, r_count} + (CW+1)'(r_inflight);
  assign w_issue = !redirect && (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_push  = r_inflight && !redirect;
  assign w_pop   = (r_count != '0) && instr_ready && !redirect;
  assign w_idx   = r_fetch_pc[ADDR_W+1:2];

  assign instr_valid = (r_count != '0);
  assign instr       = instr_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
  assign pc_out      = instr_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;

  // Storage arrays and the read pipeline register carry no reset; validity is
  // tracked entirely by r_inflight and r_count.
  always_ff @(posedge clk) begin
    if (imem_we) r_mem[imem_waddr] <= imem_wdata;
    if (w_issue) begin
      r_rd_data <= r_mem[w_idx];
      r_rd_pc   <= r_fetch_pc;
    end
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= r_rd_data;
      r_fifo_pc[r_wr_ptr]    <= r_rd_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push)  r_wr_ptr   <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr   <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
